// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives instruction-memory reads at PC, computes NEXTPC,
// and owns the IF/ID register plus a one-entry skid buffer for words returned under stall.
module if_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] PC,
  output logic [31:0] NEXTPC,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        STALL,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_PC4,
  output logic [31:0] IFID_INSTR,
  output logic        IFID_VALID
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } skid_t;

  state_e      state_q, state_d;
  ifid_t       ifid_q, ifid_d;
  skid_t       skid_q, skid_d;
  logic [31:0] pc_plus4;
  logic        imem_read;
  logic        done;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    ifid_d    = ifid_q;
    skid_d    = skid_q;
    NEXTPC    = PC;
    imem_read = 1'b0;
    done      = 1'b0;
    pc_plus4  = PC + 32'd4;

    if (RESET) begin
      NEXTPC = RESET_VECTOR;
    end else begin
      imem_read = (state_q == S_FETCH);
      done      = imem_read & ~IMEM_BUSYWAIT;

      if (BRANCH_TAKEN) begin
        // Redirect wins over stall: the wrong-path word is dropped and IF/ID bubbles.
        NEXTPC       = BRANCH_TARGET;
        ifid_d.valid = 1'b0;
        ifid_d.instr = NOP_INSTR;
        skid_d       = '0;
        state_d      = S_FLUSH;
      end else begin
        unique case (state_q)
          S_FETCH: begin
            if (done) begin
              NEXTPC = pc_plus4;
              if (STALL) begin
                skid_d  = '{pc: PC, pc4: pc_plus4, instr: IMEM_READDATA};
                state_d = S_HOLD;
              end else begin
                ifid_d = '{pc: PC, pc4: pc_plus4, instr: IMEM_READDATA, valid: 1'b1};
              end
            end else if (!STALL) begin
              ifid_d.valid = 1'b0;
              ifid_d.instr = NOP_INSTR;
            end
          end
          S_HOLD: begin
            if (!STALL) begin
              ifid_d  = '{pc: skid_q.pc, pc4: skid_q.pc4, instr: skid_q.instr, valid: 1'b1};
              state_d = S_FETCH;
            end
          end
          S_FLUSH: begin
            // Dead cycle: PC already holds the target, any in-flight access is abandoned.
            if (!STALL) begin
              ifid_d.valid = 1'b0;
              ifid_d.instr = NOP_INSTR;
            end
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_FETCH;
      ifid_q  <= '{pc: 32'd0, pc4: 32'd0, instr: NOP_INSTR, valid: 1'b0};
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ifid_q  <= ifid_d;
      skid_q  <= skid_d;
    end
  end

  assign IMEM_READ  = imem_read;
  assign IMEM_ADDR  = PC;
  assign IFID_PC    = ifid_q.pc;
  assign IFID_PC4   = ifid_q.pc4;
  assign IFID_INSTR = ifid_q.instr;
  assign IFID_VALID = ifid_q.valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed test-plan scenarios then random stall/busy/branch traffic,
// checked against a program-order scoreboard of accepted words.
module tb_if_fetch_unit;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset, branch, stall, busy;
  logic [31:0] target, pc, nextpc, imem_addr, rdata;
  logic        imem_read;
  logic [31:0] ifid_pc, ifid_pc4, ifid_instr;
  logic        ifid_valid;

  if_fetch_unit #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
    .CLOCK(clock), .RESET(reset), .PC(pc), .NEXTPC(nextpc),
    .BRANCH_TAKEN(branch), .BRANCH_TARGET(target), .STALL(stall),
    .IMEM_READ(imem_read), .IMEM_ADDR(imem_addr), .IMEM_READDATA(rdata),
    .IMEM_BUSYWAIT(busy), .IFID_PC(ifid_pc), .IFID_PC4(ifid_pc4),
    .IFID_INSTR(ifid_instr), .IFID_VALID(ifid_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: word only meaningful when not busy; garbage otherwise.
  assign rdata = busy ? 32'hDEAD_BEEF : mem_word(imem_addr);

  // PC register fed back from NEXTPC.
  initial pc = 32'd0;
  always @(posedge clock) pc <= nextpc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } word_t;

  typedef enum {E_NONE, E_RESET, E_BRANCH, E_STALL, E_ADV} edge_e;

  word_t       sb_q[$];
  edge_e       edge_kind = E_NONE;
  bit          flush_m = 1'b0;
  bit          hold_m = 1'b0;
  logic        exp_read;
  logic [31:0] exp_next;
  logic [31:0] exp_pc, exp_pc4, exp_instr;
  logic        exp_valid;
  bit          pc_known = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus side: predicts handshake outputs and pushes every accepted word.
  always @(negedge clock) begin
    if (reset) begin
      exp_read = 1'b0;
      exp_next = RV;
    end else begin
      exp_read = !flush_m && !hold_m;
      if (branch)                exp_next = target;
      else if (exp_read && !busy) exp_next = pc + 32'd4;
      else                        exp_next = pc;
    end
    check("imem_read", {31'd0, imem_read}, {31'd0, exp_read});
    check("nextpc", nextpc, exp_next);
    check("imem_addr", imem_addr, pc);

    if (reset) begin
      sb_q.delete();
      flush_m   = 1'b0;
      hold_m    = 1'b0;
      edge_kind = E_RESET;
    end else if (branch) begin
      sb_q.delete();
      flush_m   = 1'b1;
      hold_m    = 1'b0;
      edge_kind = E_BRANCH;
    end else begin
      flush_m = 1'b0;
      if (exp_read && !busy) begin
        sb_q.push_back('{pc, pc + 32'd4, mem_word(pc)});
        if (stall) hold_m = 1'b1;
      end else if (hold_m && !stall) begin
        hold_m = 1'b0;
      end
      edge_kind = stall ? E_STALL : E_ADV;
    end
  end

  // Monitor: after each edge, pops when IF/ID is free to advance and compares.
  always @(posedge clock) begin
    #1;
    if (edge_kind != E_NONE) begin
      case (edge_kind)
        E_RESET: begin
          exp_pc = 32'd0; exp_pc4 = 32'd0; exp_instr = NOP; exp_valid = 1'b0;
          pc_known = 1'b1;
        end
        E_BRANCH: begin
          exp_instr = NOP; exp_valid = 1'b0;
        end
        E_ADV: begin
          if (sb_q.size() > 0) begin
            word_t w;
            w = sb_q.pop_front();
            exp_pc = w.pc; exp_pc4 = w.pc4; exp_instr = w.instr; exp_valid = 1'b1;
            pc_known = 1'b1;
          end else begin
            exp_instr = NOP; exp_valid = 1'b0;
          end
        end
        default: ;
      endcase
      check("ifid_valid", {31'd0, ifid_valid}, {31'd0, exp_valid});
      check("ifid_instr", ifid_instr, exp_instr);
      if (pc_known && (exp_valid || edge_kind == E_RESET)) begin
        check("ifid_pc", ifid_pc, exp_pc);
        check("ifid_pc4", ifid_pc4, exp_pc4);
      end
    end
  end

  task automatic drive(input logic r, input logic b, input logic [31:0] t,
                       input logic s, input logic w);
    reset = r; branch = b; target = t; stall = s; busy = w;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; branch = 1'b0; target = 32'd0; stall = 1'b0; busy = 1'b0;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    // Streaming from 0, then busy-wait at PC=8.
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    // Stall in the cycle the word for PC=16 returns, held for four cycles.
    drive(0, 0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 1, 1);
    repeat (3) drive(0, 0, 0, 0, 0);
    // Branch to 0x100 while memory is busy and the hazard unit stalls.
    drive(0, 0, 0, 0, 1);
    drive(0, 1, 32'h0000_0100, 1, 1);
    repeat (4) drive(0, 0, 0, 0, 0);
    // Wrap across the top of the address space.
    drive(0, 1, 32'hFFFF_FFF8, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 0);
    // Reset while a word sits in the skid buffer.
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
      else                           t = $urandom & 32'h0000_FFFC;
      drive($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 6, t,
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30);
    end
    drive(0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
